// File: rtl/ultrasonic_obstacle_ranger.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_obstacle_ranger
// Brief    : Alternating left/right HC-SR04 ranger front-end producing
//            per-side obstacle flags and echo-width distances.
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_obstacle_ranger #(
    parameter int CNT_W        = 16,
    parameter int TRIG_CYCLES  = 10,
    parameter int ECHO_TIMEOUT = 1000,
    parameter int THRESH       = 300,
    parameter int GAP_CYCLES   = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             echo_left,
    input  logic             echo_right,
    output logic             trig_left,
    output logic             trig_right,
    output logic             sensor_left,
    output logic             sensor_right,
    output logic [CNT_W-1:0] dist_left,
    output logic [CNT_W-1:0] dist_right,
    output logic             meas_valid,
    output logic             meas_chan
);

    localparam logic [CNT_W-1:0] c_trig_last = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(ECHO_TIMEOUT);
    localparam logic [CNT_W-1:0] c_thresh    = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] w_width_nxt;
    logic [CNT_W-1:0] w_res_width;
    logic             r_chan;
    logic             w_chan_nxt;
    logic             w_res_wr;
    logic             w_res_timeout;
    logic             w_res_sensor;
    logic [1:0]       r_sync_l;
    logic [1:0]       r_sync_r;
    logic             w_echo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_l <= 2'b00;
            r_sync_r <= 2'b00;
        end else begin
            r_sync_l <= {r_sync_l[0], echo_left};
            r_sync_r <= {r_sync_r[0], echo_right};
        end
    end

    assign w_echo = r_chan ? r_sync_r[1] : r_sync_l[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_width <= '0;
            r_chan  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_width <= w_width_nxt;
            r_chan  <= w_chan_nxt;
        end
    end

    // Every terminal compare uses >= so a counter can never run past its bound.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_width_nxt   = r_width;
        w_chan_nxt    = r_chan;
        w_res_wr      = 1'b0;
        w_res_width   = r_width;
        w_res_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_TRIG;
                    w_cnt_nxt   = '0;
                end
            end
            S_TRIG: begin
                if (r_cnt >= c_trig_last) begin
                    w_state_nxt = S_WAIT_RISE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            S_WAIT_RISE: begin
                if (w_echo) begin
                    w_state_nxt = S_MEASURE;
                    w_width_nxt = c_one;
                end else if (r_cnt >= c_wait_last) begin
                    w_res_wr      = 1'b1;
                    w_res_width   = c_timeout;
                    w_res_timeout = 1'b1;
                    w_state_nxt   = S_GAP;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            S_MEASURE: begin
                if (!w_echo) begin
                    w_res_wr    = 1'b1;
                    w_res_width = r_width;
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end else if (r_width >= c_wait_last) begin
                    // Echo held to the limit: report as no return.
                    w_res_wr      = 1'b1;
                    w_res_width   = c_timeout;
                    w_res_timeout = 1'b1;
                    w_state_nxt   = S_GAP;
                    w_cnt_nxt     = '0;
                end else begin
                    w_width_nxt = r_width + c_one;
                end
            end
            S_GAP: begin
                if (r_cnt >= c_gap_last) begin
                    w_state_nxt = S_IDLE;
                    w_chan_nxt  = ~r_chan;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_res_sensor = (w_res_width < c_thresh) && !w_res_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_left    <= '0;
            dist_right   <= '0;
            sensor_left  <= 1'b0;
            sensor_right <= 1'b0;
            meas_valid   <= 1'b0;
            meas_chan    <= 1'b0;
        end else begin
            meas_valid <= w_res_wr;
            if (w_res_wr) begin
                meas_chan <= r_chan;
                if (r_chan) begin
                    dist_right   <= w_res_width;
                    sensor_right <= w_res_sensor;
                end else begin
                    dist_left   <= w_res_width;
                    sensor_left <= w_res_sensor;
                end
            end
        end
    end

    assign trig_left  = (r_state == S_TRIG) && !r_chan;
    assign trig_right = (r_state == S_TRIG) && r_chan;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_obstacle_ranger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_obstacle_ranger
// Brief    : Self-checking bench; acts as both rangers and predicts results
//            from the echo widths it generates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_obstacle_ranger;

    localparam int CNT_W        = 16;
    localparam int TRIG_CYCLES  = 4;
    localparam int ECHO_TIMEOUT = 100;
    localparam int THRESH       = 30;
    localparam int GAP_CYCLES   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             echo_left = 1'b0;
    logic             echo_right = 1'b0;
    logic             trig_left;
    logic             trig_right;
    logic             sensor_left;
    logic             sensor_right;
    logic [CNT_W-1:0] dist_left;
    logic [CNT_W-1:0] dist_right;
    logic             meas_valid;
    logic             meas_chan;

    int n_pass  = 0;
    int n_total = 0;
    int exp_dist [2];
    bit exp_sens [2];
    bit exp_chan;

    ultrasonic_obstacle_ranger #(
        .CNT_W       (CNT_W),
        .TRIG_CYCLES (TRIG_CYCLES),
        .ECHO_TIMEOUT(ECHO_TIMEOUT),
        .THRESH      (THRESH),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .echo_left   (echo_left),
        .echo_right  (echo_right),
        .trig_left   (trig_left),
        .trig_right  (trig_right),
        .sensor_left (sensor_left),
        .sensor_right(sensor_right),
        .dist_left   (dist_left),
        .dist_right  (dist_right),
        .meas_valid  (meas_valid),
        .meas_chan   (meas_chan)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_dist[0] = 0;
        exp_dist[1] = 0;
        exp_sens[0] = 1'b0;
        exp_sens[1] = 1'b0;
        exp_chan    = 1'b0;
    endtask

    // width 0 = no echo at all; widths at or beyond the timeout read as no return.
    task automatic run_measurement(input int width, input int delay, input bit noise,
                                   input bit drop_en, input string tag);
        bit got;
        bit side;
        bit drive;
        int tw;
        int ed;
        bit es;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            step();
            if (trig_left || trig_right) begin
                got = 1'b1;
                break;
            end
        end
        n_total++;
        if (!got) begin
            $display("FAIL %s trig_seen: got none in 100 cycles, expected trig side %0d", tag, exp_chan);
            return;
        end
        side = trig_right;
        if ((side !== exp_chan) || (trig_left && trig_right))
            $display("FAIL %s trig_side: got L=%0b R=%0b, expected side %0d", tag, trig_left, trig_right, exp_chan);
        else
            n_pass++;
        tw = 0;
        while ((trig_left || trig_right) && tw < 50) begin
            tw++;
            step();
        end
        n_total++;
        if (tw !== TRIG_CYCLES)
            $display("FAIL %s trig_width: got %0d cycles, expected %0d", tag, tw, TRIG_CYCLES);
        else
            n_pass++;
        if (drop_en) enable = 1'b0;

        got = 1'b0;
        for (int t = 0; t < 400; t++) begin
            drive = (width > 0) && (t >= delay) && (t < delay + width);
            if (side) begin
                echo_right = drive;
                echo_left  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                echo_left  = drive;
                echo_right = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            step();
            if (meas_valid) begin
                got = 1'b1;
                break;
            end
        end
        echo_left  = 1'b0;
        echo_right = 1'b0;

        if (width == 0 || width >= ECHO_TIMEOUT) begin
            ed = ECHO_TIMEOUT;
            es = 1'b0;
        end else begin
            ed = width;
            es = (width < THRESH);
        end
        exp_dist[side] = ed;
        exp_sens[side] = es;

        n_total++;
        if (!got) begin
            $display("FAIL %s meas_valid_seen: got none in 400 cycles, expected a pulse", tag);
        end else begin
            n_pass++;
            n_total++;
            if (meas_chan !== side)
                $display("FAIL %s meas_chan: got %0b expected %0b", tag, meas_chan, side);
            else
                n_pass++;
        end
        n_total++;
        if (dist_left !== CNT_W'(exp_dist[0]) || sensor_left !== exp_sens[0])
            $display("FAIL %s left_result: got dist=%0d sensor=%0b expected dist=%0d sensor=%0b",
                     tag, dist_left, sensor_left, exp_dist[0], exp_sens[0]);
        else
            n_pass++;
        n_total++;
        if (dist_right !== CNT_W'(exp_dist[1]) || sensor_right !== exp_sens[1])
            $display("FAIL %s right_result: got dist=%0d sensor=%0b expected dist=%0d sensor=%0b",
                     tag, dist_right, sensor_right, exp_dist[1], exp_sens[1]);
        else
            n_pass++;
        step();
        n_total++;
        if (meas_valid !== 1'b0)
            $display("FAIL %s meas_valid_pulse: got %0b one cycle later, expected 0", tag, meas_valid);
        else
            n_pass++;
        exp_chan = ~exp_chan;
    endtask

    task automatic align_to(input bit side);
        if (exp_chan !== side)
            run_measurement(int'($urandom_range(1, 60)), int'($urandom_range(0, 10)), 1'b0, 1'b0, "align");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total++;
        if ({trig_left, trig_right, sensor_left, sensor_right, dist_left, dist_right,
             meas_valid, meas_chan} !== '0)
            $display("FAIL reset_outputs: got L=%0d R=%0d sL=%0b sR=%0b v=%0b, expected all 0",
                     dist_left, dist_right, sensor_left, sensor_right, meas_valid);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_left_obstacle();
        align_to(1'b0);
        run_measurement(20, int'($urandom_range(0, 10)), 1'b0, 1'b0, "left20");
    endtask

    task automatic test_right_threshold();
        align_to(1'b1);
        run_measurement(29, int'($urandom_range(0, 10)), 1'b0, 1'b0, "right29");
        run_measurement(int'($urandom_range(1, 60)), 3, 1'b0, 1'b0, "left_between");
        run_measurement(30, int'($urandom_range(0, 10)), 1'b0, 1'b0, "right30");
    endtask

    task automatic test_no_echo();
        align_to(1'b0);
        run_measurement(0, 0, 1'b0, 1'b0, "left_none");
    endtask

    task automatic test_stuck_high();
        align_to(1'b0);
        run_measurement(150, int'($urandom_range(0, 10)), 1'b1, 1'b0, "left_stuck");
    endtask

    task automatic test_enable_drop();
        int trig_seen;
        int hold_l;
        int hold_r;
        run_measurement(int'($urandom_range(1, 60)), 5, 1'b0, 1'b1, "drop_en");
        hold_l = exp_dist[0];
        hold_r = exp_dist[1];
        trig_seen = 0;
        for (int t = 0; t < 60; t++) begin
            step();
            if (trig_left || trig_right) trig_seen++;
        end
        n_total++;
        if (trig_seen !== 0)
            $display("FAIL parked_no_trig: got %0d trig cycles while parked, expected 0", trig_seen);
        else
            n_pass++;
        n_total++;
        if (dist_left !== CNT_W'(hold_l) || dist_right !== CNT_W'(hold_r))
            $display("FAIL parked_hold: got L=%0d R=%0d expected L=%0d R=%0d",
                     dist_left, dist_right, hold_l, hold_r);
        else
            n_pass++;
        enable = 1'b1;
        run_measurement(int'($urandom_range(1, 60)), 2, 1'b0, 1'b0, "resume");
    endtask

    task automatic test_reset_mid_measure();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            step();
            if (trig_left || trig_right) begin
                got = 1'b1;
                break;
            end
        end
        while (trig_left || trig_right) step();
        echo_left  = 1'b1;
        echo_right = 1'b1;
        for (int t = 0; t < 8; t++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (!got || {trig_left, trig_right, sensor_left, sensor_right, dist_left, dist_right,
                     meas_valid, meas_chan} !== '0)
            $display("FAIL midreset_outputs: got trig_seen=%0b L=%0d R=%0d sL=%0b sR=%0b, expected all 0",
                     got, dist_left, dist_right, sensor_left, sensor_right);
        else
            n_pass++;
        echo_left  = 1'b0;
        echo_right = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
        run_measurement(int'($urandom_range(1, 60)), 4, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int kind;
        int w;
        for (int i = 0; i < 10; i++) begin
            kind = int'($urandom_range(0, 5));
            if (kind == 0)      w = 0;
            else if (kind == 1) w = int'($urandom_range(100, 140));
            else                w = int'($urandom_range(1, 99));
            run_measurement(w, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        enable = 1'b1;
        test_left_obstacle();
        test_right_threshold();
        test_no_echo();
        test_stuck_high();
        test_enable_drop();
        test_reset_mid_measure();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
